vector_pair_loader: RTL and testbench

//   Upstream feeder for the vector adder. Collects a stream of signed element pairs
//   (a[i], b[i]), one pair per accepted beat, into two N-element register arrays.

---
 rtl/vector_pair_loader.sv | 81 ++++++++
 tb/tb_vector_pair_loader.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_pair_loader.sv
// Vector pair loader: gathers signed (a,b) element pairs into two N-deep
// arrays and presents the completed vectors to the adder under valid/ready.
module vector_pair_loader #(
  parameter int N = 400,
  parameter int W = 32,
  localparam int CW = $clog2(N + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] in_a,
  input  logic signed [W-1:0] in_b,
  input  logic                in_last,
  output logic                vec_valid,
  input  logic                vec_ready,
  output logic signed [W-1:0] vec_a [0:N-1],
  output logic signed [W-1:0] vec_b [0:N-1],
  output logic [CW-1:0]       count,
  output logic                len_err
);

  localparam int IW = $clog2(N);

  typedef enum logic {
    LOAD = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic          at_end;

  assign in_ready  = (state == LOAD);
  assign vec_valid = (state == HOLD);
  assign at_end    = (idx == IW'(N - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= LOAD;
      idx     <= '0;
      count   <= '0;
      len_err <= 1'b0;
      for (int i = 0; i < N; i++) begin
        vec_a[i] <= '0;
        vec_b[i] <= '0;
      end
    end else begin
      len_err <= 1'b0;
      unique case (state)
        LOAD: begin
          if (in_valid) begin
            vec_a[idx] <= in_a;
            vec_b[idx] <= in_b;
            if (at_end) begin
              // a full vector is presented even if in_last was missing
              idx     <= '0;
              count   <= CW'(N);
              state   <= HOLD;
              len_err <= ~in_last;
            end else if (in_last) begin
              idx     <= '0;
              count   <= '0;
              len_err <= 1'b1;
            end else begin
              idx   <= idx + IW'(1);
              count <= CW'(idx) + CW'(1);
            end
          end
        end
        HOLD: begin
          if (vec_ready) begin
            state <= LOAD;
            count <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vector_pair_loader.sv
// Self-checking bench for vector_pair_loader: directed N=4 scenarios
// plus a randomized N=400 run against a queue-based reference model.
module tb_vector_pair_loader;

  localparam int SN = 4;
  localparam int BN = 400;
  localparam int W  = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // small instance
  logic                s_valid = 0, s_last = 0, s_vr = 0;
  logic signed [W-1:0] s_a = 0, s_b = 0;
  logic                s_ready, s_vv, s_err;
  logic signed [W-1:0] s_va [0:SN-1];
  logic signed [W-1:0] s_vb [0:SN-1];
  logic [$clog2(SN+1)-1:0] s_cnt;

  vector_pair_loader #(.N(SN), .W(W)) u_small (
    .clk(clk), .rst(rst),
    .in_valid(s_valid), .in_ready(s_ready),
    .in_a(s_a), .in_b(s_b), .in_last(s_last),
    .vec_valid(s_vv), .vec_ready(s_vr),
    .vec_a(s_va), .vec_b(s_vb),
    .count(s_cnt), .len_err(s_err)
  );

  // large instance
  logic                b_valid = 0, b_last = 0, b_vr = 0;
  logic signed [W-1:0] b_a = 0, b_b = 0;
  logic                b_ready, b_vv, b_err;
  logic signed [W-1:0] b_va [0:BN-1];
  logic signed [W-1:0] b_vb [0:BN-1];
  logic [$clog2(BN+1)-1:0] b_cnt;

  vector_pair_loader #(.N(BN), .W(W)) u_big (
    .clk(clk), .rst(rst),
    .in_valid(b_valid), .in_ready(b_ready),
    .in_a(b_a), .in_b(b_b), .in_last(b_last),
    .vec_valid(b_vv), .vec_ready(b_vr),
    .vec_a(b_va), .vec_b(b_vb),
    .count(b_cnt), .len_err(b_err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sbeat(input logic [31:0] a,
                       input logic [31:0] b,
                       input logic last);
    s_valid = 1'b1;
    s_a = a;
    s_b = b;
    s_last = last;
    step();
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic chk_small(input string tag,
                           input logic [31:0] ea [0:SN-1],
                           input logic [31:0] eb [0:SN-1]);
    for (int i = 0; i < SN; i++) begin
      chk($sformatf("%s_a%0d", tag, i), s_va[i], ea[i]);
      chk($sformatf("%s_b%0d", tag, i), s_vb[i], eb[i]);
    end
  endtask

  task automatic release_small();
    s_vr = 1'b1;
    step();
    s_vr = 1'b0;
  endtask

  logic [31:0] ea [0:SN-1];
  logic [31:0] eb [0:SN-1];

  // reference model state for the randomized run
  logic [31:0] qa [$];
  logic [31:0] qb [$];
  int  k;
  bit  hold;
  bit  seen;
  int  vecs;
  int  cyc;

  initial begin
    step();
    step();
    rst = 1'b0;
    step();

    chk("rst_ready", 32'(s_ready), 1);
    chk("rst_vvalid", 32'(s_vv), 0);
    chk("rst_count", 32'(s_cnt), 0);
    chk("rst_err", 32'(s_err), 0);
    chk("rst_va0", s_va[0], 0);

    // 1: clean 4-beat vector
    sbeat(1, 10, 0);
    chk("t1_err1", 32'(s_err), 0);
    sbeat(2, 20, 0);
    chk("t1_cnt2", 32'(s_cnt), 2);
    chk("t1_vv2", 32'(s_vv), 0);
    sbeat(3, 30, 0);
    sbeat(4, 40, 1);
    chk("t1_vv", 32'(s_vv), 1);
    chk("t1_ready", 32'(s_ready), 0);
    chk("t1_cnt", 32'(s_cnt), 4);
    chk("t1_err", 32'(s_err), 0);
    ea = '{1, 2, 3, 4};
    eb = '{10, 20, 30, 40};
    chk_small("t1", ea, eb);

    // 2: hold with downstream stalled, input pushing garbage
    s_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      s_a = $urandom;
      s_b = $urandom;
      s_last = 1'($urandom_range(0, 1));
      step();
      chk("t2_ready", 32'(s_ready), 0);
      chk("t2_vv", 32'(s_vv), 1);
    end
    s_valid = 1'b0;
    s_last = 1'b0;
    chk_small("t2", ea, eb);
    chk("t2_cnt", 32'(s_cnt), 4);
    release_small();
    chk("t2_rel_vv", 32'(s_vv), 0);
    chk("t2_rel_ready", 32'(s_ready), 1);
    chk("t2_rel_cnt", 32'(s_cnt), 0);

    // 3: short vector then a good one
    sbeat(5, 50, 0);
    sbeat(6, 60, 1);
    chk("t3_err", 32'(s_err), 1);
    chk("t3_cnt", 32'(s_cnt), 0);
    chk("t3_vv", 32'(s_vv), 0);
    step();
    chk("t3_err_off", 32'(s_err), 0);
    sbeat(7, 70, 0);
    sbeat(8, 80, 0);
    sbeat(9, 90, 0);
    sbeat(11, 110, 1);
    chk("t3_vv2", 32'(s_vv), 1);
    chk("t3_err2", 32'(s_err), 0);
    ea = '{7, 8, 9, 11};
    eb = '{70, 80, 90, 110};
    chk_small("t3", ea, eb);
    release_small();

    // 4: full vector without in_last
    sbeat(21, 31, 0);
    sbeat(22, 32, 0);
    sbeat(23, 33, 0);
    sbeat(24, 34, 0);
    chk("t4_err", 32'(s_err), 1);
    chk("t4_vv", 32'(s_vv), 1);
    ea = '{21, 22, 23, 24};
    eb = '{31, 32, 33, 34};
    chk_small("t4", ea, eb);
    step();
    chk("t4_err_off", 32'(s_err), 0);
    release_small();

    // 5: signed extremes
    sbeat(32'h8000_0000, 32'h7fff_ffff, 0);
    sbeat(32'h7fff_ffff, 32'h8000_0000, 0);
    sbeat(32'hffff_ffff, 32'h0000_0001, 0);
    sbeat(32'h0000_0000, 32'hffff_ffff, 1);
    ea = '{32'h8000_0000, 32'h7fff_ffff, 32'hffff_ffff, 0};
    eb = '{32'h7fff_ffff, 32'h8000_0000, 1, 32'hffff_ffff};
    chk("t5_vv", 32'(s_vv), 1);
    chk_small("t5", ea, eb);
    release_small();

    // 6: reset in the middle of a vector
    sbeat(41, 51, 0);
    sbeat(42, 52, 0);
    sbeat(43, 53, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t6_cnt", 32'(s_cnt), 0);
    chk("t6_vv", 32'(s_vv), 0);
    chk("t6_ready", 32'(s_ready), 1);
    chk("t6_va0", s_va[0], 0);
    chk("t6_vb2", s_vb[2], 0);
    step();
    rst = 1'b0;
    step();
    sbeat(61, 71, 0);
    sbeat(62, 72, 0);
    sbeat(63, 73, 0);
    sbeat(64, 74, 1);
    chk("t6_vv2", 32'(s_vv), 1);
    ea = '{61, 62, 63, 64};
    eb = '{71, 72, 73, 74};
    chk_small("t6", ea, eb);
    release_small();

    // 7: randomized N=400 stream against the reference model
    k = 0;
    hold = 0;
    seen = 0;
    vecs = 0;
    cyc = 0;
    while (vecs < 5 && cyc < 20000) begin
      chk("t7_ready", 32'(b_ready), 32'(!hold));
      chk("t7_vv", 32'(b_vv), 32'(hold));
      chk("t7_cnt", 32'(b_cnt), hold ? BN : k);
      chk("t7_err", 32'(b_err), 0);
      if (hold && !seen) begin
        seen = 1;
        for (int i = 0; i < BN; i++) begin
          chk("t7_a", b_va[i], qa[i]);
          chk("t7_b", b_vb[i], qb[i]);
        end
      end
      b_valid = ($urandom_range(0, 3) != 0);
      b_a = $urandom;
      b_b = $urandom;
      b_last = hold ? 1'($urandom_range(0, 1)) : (k == BN - 1);
      b_vr = ($urandom_range(0, 2) == 0);
      if (hold) begin
        if (b_vr) begin
          hold = 0;
          k = 0;
          qa.delete();
          qb.delete();
          vecs++;
        end
      end else if (b_valid) begin
        qa.push_back(b_a);
        qb.push_back(b_b);
        k++;
        if (k == BN) begin
          hold = 1;
          seen = 0;
        end
      end
      step();
      cyc++;
    end
    b_valid = 1'b0;
    b_vr = 1'b0;
    chk("t7_vectors", vecs, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
